// File: rtl/relu_backward.sv
// ReLU backward stage: LIFO of forward derivative masks gating gradients.
// Optional leaky gating of masked elements with RELU_BWD_LEAKY_EN.
`ifndef N
`define N 16
`endif

module relu_backward #(
    parameter int Size      = 3,
    parameter int Depth     = 4,
    parameter int LeakShift = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         fwd_valid,
    output logic                         fwd_ready,
    input  logic [`N-1:0]                fwd_a [0:Size-1],
    input  logic                         bwd_valid,
    output logic                         bwd_ready,
    input  logic [`N-1:0]                bwd_g [0:Size-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`N-1:0]                out_g [0:Size-1],
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int CW = $clog2(Depth + 1);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Size-1:0] stack [Depth];
    logic [Size-1:0] mask;
    logic [Size-1:0] top;
    logic            push;
    logic            pop;
    logic [CW-1:0]   rd_ptr;
    logic [CW-1:0]   wr_ptr;
    logic [`N-1:0]   gated [Size];

    function automatic logic [`N-1:0] leak(input logic [`N-1:0] g);
        logic [`N-2:0] mag;
        mag = g[`N-2:0] >> LeakShift;
        leak = (mag == '0) ? '0 : {g[`N-1], mag};
    endfunction

    assign bwd_ready = (count != '0) && (!out_valid || out_ready);
    assign pop       = bwd_valid && bwd_ready && !flush;
    assign fwd_ready = (count < CW'(Depth)) || pop;
    assign push      = fwd_valid && fwd_ready && !flush;

    // A simultaneous push replaces the entry being popped.
    assign rd_ptr = count - CW'(1);
    assign wr_ptr = pop ? rd_ptr : count;
    assign top    = stack[rd_ptr[AW-1:0]];

    always_comb begin
        for (int i = 0; i < Size; i++) begin
            mask[i] = !fwd_a[i][`N-1] && (fwd_a[i][`N-2:0] != '0);
        end
    end

    always_comb begin
        for (int i = 0; i < Size; i++) begin
`ifdef RELU_BWD_LEAKY_EN
            gated[i] = top[i] ? bwd_g[i] : leak(bwd_g[i]);
`else
            gated[i] = top[i] ? bwd_g[i] : '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                stack[i] <= '0;
            end
        end else if (push) begin
            stack[wr_ptr[AW-1:0]] <= mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int i = 0; i < Size; i++) begin
                out_g[i] <= '0;
            end
        end else if (flush) begin
            out_valid <= 1'b0;
            for (int i = 0; i < Size; i++) begin
                out_g[i] <= '0;
            end
        end else if (pop) begin
            out_valid <= 1'b1;
            for (int i = 0; i < Size; i++) begin
                out_g[i] <= gated[i];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward with a queue-based reference model.
`ifndef N
`define N 16
`endif

module tb_relu_backward;

    localparam int SZ = 3;
    localparam int DP = 4;
    localparam int LS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [`N-1:0] fwd_a [0:SZ-1];
    logic          bwd_valid;
    logic          bwd_ready;
    logic [`N-1:0] bwd_g [0:SZ-1];
    logic          out_valid;
    logic          out_ready;
    logic [`N-1:0] out_g [0:SZ-1];
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    relu_backward #(.Size(SZ), .Depth(DP), .LeakShift(LS)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_a(fwd_a),
        .bwd_valid(bwd_valid), .bwd_ready(bwd_ready), .bwd_g(bwd_g),
        .out_valid(out_valid), .out_ready(out_ready), .out_g(out_g),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of masks, top of stack at the back.
    typedef logic [SZ-1:0] mask_t;
    mask_t         q [$];
    logic          mv;
    logic [`N-1:0] mg [SZ];

    function automatic logic m_ready_bwd();
        return (q.size() != 0) && (!mv || out_ready);
    endfunction

    function automatic logic [`N-1:0] m_gate(input logic m,
                                             input logic [`N-1:0] g);
        int mag;
        if (m) return g;
`ifdef RELU_BWD_LEAKY_EN
        mag = int'(g[`N-2:0]) / (1 << LS);
        if (mag == 0) return '0;
        return {g[`N-1], mag[`N-2:0]};
`else
        mag = 0;
        return `N'(mag);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mv = 1'b0;
            for (int i = 0; i < SZ; i++) mg[i] = '0;
        end else if (flush) begin
            q.delete();
            mv = 1'b0;
            for (int i = 0; i < SZ; i++) mg[i] = '0;
        end else begin
            logic  p_pop, p_push;
            mask_t nm, tp;
            p_pop  = bwd_valid && m_ready_bwd();
            p_push = fwd_valid && (q.size() < DP || p_pop);
            for (int i = 0; i < SZ; i++)
                nm[i] = (fwd_a[i][`N-1] == 1'b0) && (fwd_a[i][`N-2:0] != 0);
            if (p_pop) begin
                tp = q.pop_back();
                for (int i = 0; i < SZ; i++) mg[i] = m_gate(tp[i], bwd_g[i]);
                mv = 1'b1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            if (p_push) q.push_back(nm);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic b;
            b = m_ready_bwd();
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(mv));
            chk("bwd_ready", 32'(bwd_ready), 32'(b));
            chk("fwd_ready", 32'(fwd_ready),
                32'((q.size() < DP) || (bwd_valid && b)));
            if (mv) begin
                for (int i = 0; i < SZ; i++)
                    chk($sformatf("out_g[%0d]", i), 32'(out_g[i]), 32'(mg[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [`N-1:0] a0, a1, a2);
        fwd_a[0] = a0; fwd_a[1] = a1; fwd_a[2] = a2;
    endtask

    task automatic set_g(input logic [`N-1:0] g0, g1, g2);
        bwd_g[0] = g0; bwd_g[1] = g1; bwd_g[2] = g2;
    endtask

    task automatic exp_out(input string nm, input logic [`N-1:0] e0, e1, e2);
        chk({nm, ".v"}, 32'(out_valid), 32'd1);
        chk({nm, ".g0"}, 32'(out_g[0]), 32'(e0));
        chk({nm, ".g1"}, 32'(out_g[1]), 32'(e1));
        chk({nm, ".g2"}, 32'(out_g[2]), 32'(e2));
    endtask

    task automatic push1(input logic [`N-1:0] a0, a1, a2);
        set_a(a0, a1, a2);
        fwd_valid = 1'b1;
        step();
        fwd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0;
        out_ready = 1'b1;
        set_a(0, 0, 0);
        set_g(0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.fwd_ready", 32'(fwd_ready), 32'd1);
        chk("rst.bwd_ready", 32'(bwd_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.g0", 32'(out_g[0]), 32'd0);

        // Mask gating
        push1(16'h0100, 16'h8100, 16'h0000);
        chk("gate.count1", 32'(count), 32'd1);
        set_g(16'h0200, 16'h0300, 16'h0400);
        bwd_valid = 1'b1;
        step();
        bwd_valid = 1'b0;
        exp_out("gate", 16'h0200, 16'h0000, 16'h0000);
        chk("gate.count0", 32'(count), 32'd0);
        step();

        // LIFO order
        push1(16'h0100, 16'h0100, 16'h8100);
        push1(16'h8100, 16'h0100, 16'h0100);
        set_g(16'h0100, 16'h0100, 16'h0100);
        bwd_valid = 1'b1;
        step();
        exp_out("lifo1", 16'h0000, 16'h0100, 16'h0100);
        step();
        bwd_valid = 1'b0;
        exp_out("lifo2", 16'h0100, 16'h0100, 16'h0000);
        step();

        // Full / empty
        push1(16'h0001, 16'h0001, 16'h0001);
        push1(16'h0002, 16'h8002, 16'h0002);
        push1(16'h0003, 16'h0003, 16'h8003);
        push1(16'h8004, 16'h0004, 16'h0004);
        chk("full.count", 32'(count), 32'd4);
        chk("full.fwd_ready", 32'(fwd_ready), 32'd0);
        push1(16'h0005, 16'h0005, 16'h0005);
        chk("full.count5", 32'(count), 32'd4);
        set_g(16'h0011, 16'h0022, 16'h0033);
        bwd_valid = 1'b1;
        step();
        exp_out("full.pop1", 16'h0000, 16'h0022, 16'h0033);
        repeat (3) step();
        bwd_valid = 1'b0;
        exp_out("full.pop4", 16'h0011, 16'h0022, 16'h0033);
        chk("empty.bwd_ready", 32'(bwd_ready), 32'd0);
        chk("empty.count", 32'(count), 32'd0);
        step();

        // Backpressure
        push1(16'h0100, 16'h0100, 16'h0100);
        push1(16'h0100, 16'h8100, 16'h0100);
        out_ready = 1'b0;
        set_g(16'h0700, 16'h0700, 16'h0700);
        bwd_valid = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_out("bp.hold", 16'h0700, 16'h0000, 16'h0700);
            chk("bp.bwd_ready", 32'(bwd_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release", 32'(bwd_ready), 32'd1);
        step();
        bwd_valid = 1'b0;
        exp_out("bp.next", 16'h0700, 16'h0700, 16'h0700);
        step();

        // Simultaneous push and pop
        push1(16'h0100, 16'h0100, 16'h0100);
        push1(16'h8000, 16'h0100, 16'h0000);
        set_a(16'h0100, 16'h8100, 16'h0001);
        set_g(16'h0111, 16'h0222, 16'h0333);
        fwd_valid = 1'b1;
        bwd_valid = 1'b1;
        step();
        fwd_valid = 1'b0;
        exp_out("sim.old", 16'h0000, 16'h0222, 16'h0000);
        chk("sim.count", 32'(count), 32'd2);
        step();
        exp_out("sim.c", 16'h0111, 16'h0000, 16'h0333);
        step();
        bwd_valid = 1'b0;
        exp_out("sim.d", 16'h0111, 16'h0222, 16'h0333);
        step();

        // Masked-element gating (leaky or zero)
        push1(16'h8001, 16'h0000, 16'h0100);
        set_g(16'h8040, 16'h0004, 16'h0100);
        bwd_valid = 1'b1;
        step();
        bwd_valid = 1'b0;
`ifdef RELU_BWD_LEAKY_EN
        exp_out("leaky", 16'h8008, 16'h0000, 16'h0100);
`else
        exp_out("masked", 16'h0000, 16'h0000, 16'h0100);
`endif
        step();

        // Flush
        repeat (4) push1(16'h0100, 16'h0100, 16'h0100);
        out_ready = 1'b0;
        bwd_valid = 1'b1;
        step();
        bwd_valid = 1'b0;
        chk("fl.count3", 32'(count), 32'd3);
        chk("fl.ov1", 32'(out_valid), 32'd1);
        flush = 1'b1;
        fwd_valid = 1'b1;
        step();
        flush = 1'b0;
        fwd_valid = 1'b0;
        chk("fl.count", 32'(count), 32'd0);
        chk("fl.ov", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();

        // Asynchronous reset mid-cycle
        push1(16'h0100, 16'h0100, 16'h0100);
        out_ready = 1'b0;
        set_g(16'h0123, 16'h0456, 16'h0789);
        bwd_valid = 1'b1;
        step();
        bwd_valid = 1'b0;
        chk("ar.ov1", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar.ov", 32'(out_valid), 32'd0);
        chk("ar.count", 32'(count), 32'd0);
        chk("ar.g1", 32'(out_g[1]), 32'd0);
        chk("ar.fwd_ready", 32'(fwd_ready), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_backward.md
# relu_backward

Backward-pass companion to the feedforward ReLU activation stage. During the forward pass it captures one ReLU derivative mask per activation vector onto a LIFO stack. During backpropagation it pops those masks in reverse layer order and gates each incoming gradient vector elementwise. It sits between the layer's forward activation output and the backward gradient datapath. All data words are `N`-bit signed magnitude from `config.svh`.

## Interface
Parameters:
- Size, 3 — elements per vector
- Depth, 4 — mask stack entries (layers/samples buffered)
- LeakShift, 3 — magnitude right-shift for masked elements (only with `RELU_BWD_LEAKY_EN`)

Ports:
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-high reset
- flush  in  1  — synchronous clear of stack and output register
- fwd_valid  in  1  — forward pre-activation vector valid
- fwd_ready  out  1  — stack can accept a push
- fwd_a  in  [`N-1:0] x Size  — pre-activation vector (unpacked array [0:Size-1])
- bwd_valid  in  1  — incoming gradient vector valid
- bwd_ready  out  1  — gradient accepted this cycle
- bwd_g  in  [`N-1:0] x Size  — incoming gradient vector
- out_valid  out  1  — gated gradient valid
- out_ready  in  1  — downstream accepts out_g
- out_g  out  [`N-1:0] x Size  — gated gradient vector
- count  out  $clog2(Depth+1)  — current stack occupancy

## Operation
- Mask bit m[i] = 1 iff fwd_a[i][N-1]==0 and fwd_a[i][N-2:0]!=0. +0, -0, and negatives all give 0.
- Push fires on fwd_valid && fwd_ready. It writes the Size-bit mask to entry[count] and increments count.
- Pop fires on bwd_valid && bwd_ready. It reads entry[count-1], decrements count, and loads out_g[i] = m[i] ? bwd_g[i] : 16'... all-zero word (+0).
- Push and pop in the same cycle:
  - The pop uses the old top entry[count-1].
  - The push overwrites entry[count-1].
  - count is unchanged.
- fwd_ready = (count < Depth) || pop firing this cycle. When full, a push is accepted only alongside a pop.
- bwd_ready = (count != 0) && (!out_valid || out_ready).
- Output register behaviour:
  - Loaded on pop; out_valid set.
  - Cleared when out_valid && out_ready with no new pop.
  - Holds value and out_valid while out_ready=0.
- flush:
  - count ← 0 and out_valid ← 0.
  - Overrides push and pop that cycle; neither fires and both inputs are ignored.
  - Stack contents are don't-care.
- No combinational path from fwd_a or bwd_g to out_g.

## Timing
- Reset values: count=0, out_valid=0, out_g all zero.
  - fwd_ready=1 after reset.
  - bwd_ready=0 after reset.
  - Stack entries reset to 0.
- Pop latency: out_g is valid the cycle after the pop handshake.
- Throughput: one pop per cycle when out_ready is held at 1.
- Push is visible to a pop on the next cycle. A same-cycle push and pop on an empty stack does not pop.
- Reset asserted mid-transfer drops any pending output immediately and asynchronously.
- Full (count==Depth): fwd_ready=0 unless a pop fires.
- Empty (count==0): bwd_ready=0.

## Configuration
- `RELU_BWD_LEAKY_EN` defined:
  - A masked element outputs the sign of bwd_g[i] with magnitude bwd_g[i][N-2:0] >> LeakShift.
  - If the shifted magnitude is 0, the output is +0 (sign forced to 0).
  - Unmasked elements pass unchanged.
- Not defined: masked elements output +0, and LeakShift is unused.

## Test plan
Assume `N`=16.
- Mask gating: after reset, push fwd_a={0x0100, 0x8100, 0x0000}, then pop with bwd_g={0x0200, 0x0300, 0x0400} → one cycle later out_valid=1 and out_g={0x0200, 0x0000, 0x0000}. Also check count goes 0→1→0.
- LIFO order: push masks A={+,+,−}, B={−,+,+}, then pop twice with bwd_g all 0x0100 → first out_g={0, 0x0100, 0x0100}, second out_g={0x0100, 0x0100, 0}.
- Full/empty: push Depth=4 vectors → count=4 and fwd_ready=0, and a 5th push is not accepted. Pop 4 times → bwd_ready=0 and count=0.
- Backpressure: hold out_ready=0 after one pop → out_g stable and bwd_ready=0 for 5 cycles. Raise out_ready → the next pop is accepted the same cycle.
- Simultaneous: with count=2, push C and pop in the same cycle → out_g uses the old top, count stays 2, and the next pop uses C.
- Leaky (`RELU_BWD_LEAKY_EN`, LeakShift=3): masked element with bwd_g=0x8040 → 0x8008; with 0x0004 → 0x0000.
- Flush/reset: flush with count=3 and out_valid=1 → next cycle count=0 and out_valid=0. Async rst mid-cycle → outputs are at reset values before the next edge.
